// File: rtl/intr_flag_ctrl_pkg.sv
// Shared definitions for the interrupt/return sequencer: state encoding,
// memory address-select codes and the condition-code flag width.
package intr_flag_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    DRAIN = 4'd1,
    SAVE  = 4'd2,
    PUSH  = 4'd3,
    VEC   = 4'd4,
    JUMP  = 4'd5,
    POP   = 4'd6,
    POPRD = 4'd7,
    RET   = 4'd8
  } state_t;

  localparam logic [1:0] SEL_NORM = 2'b00;
  localparam logic [1:0] SEL_SP   = 2'b01;
  localparam logic [1:0] SEL_VEC  = 2'b10;

  // Z, N, C, V held in the downstream condition-code register
  localparam int FLAG_W = 4;

endpackage

// File: rtl/intr_flag_ctrl_edge.sv
// intr_edge_sync: optional 2-flop synchronizer, rising-edge detect and the
// pending latch. Define INTR_SYNC_EN to insert the synchronizer (+2 cycles).
module intr_edge_sync
  import intr_flag_ctrl_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic intr,
  input  logic clr,
  output logic pending
);

  logic intr_s;
  logic intr_q;
  logic rise;

`ifdef INTR_SYNC_EN
  logic [1:0] sync;

  // two-stage synchronizer for an INTR driven from another clock domain
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync <= '0;
    else      sync <= {sync[0], intr};
  end

  assign intr_s = sync[1];
`else
  assign intr_s = intr;
`endif

  assign rise = intr_s & ~intr_q;

  // edge register plus pending latch; clear wins, so an edge coinciding with
  // entry to DRAIN is absorbed into the service being started
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      intr_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      intr_q <= intr_s;
      if (clr)       pending <= 1'b0;
      else if (rise) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/intr_flag_ctrl.sv
// intr_flag_ctrl: single-level interrupt entry / RTI sequencer for the 8-bit
// core. Drains the pipe, saves flags, pushes the return PC, fetches the
// vector and redirects fetch; RTI pops the PC and restores flags.
// Optional build macro: INTR_SYNC_EN (synchronize INTR, +2 cycles entry).
module intr_flag_ctrl
  import intr_flag_ctrl_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [7:0]  VECTOR_ADDR  = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic       RTI,
  input  logic [7:0] PC_NEXT,
  input  logic [7:0] MEM_RDATA,
  output logic       STALL,
  output logic       FLUSH,
  output logic       F_SAVE,
  output logic       F_RESTORE,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic [1:0] MEM_ADDR_SEL,
  output logic [7:0] MEM_WDATA,
  output logic       SP_DEC,
  output logic       SP_INC,
  output logic       PC_LOAD,
  output logic [7:0] PC_LOAD_VAL,
  output logic       INT_ACK,
  output logic       IN_SERVICE
);

  // VECTOR_ADDR is decoded by the memory address mux from SEL_VEC
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7 || $bits(VECTOR_ADDR) != 8) begin : g_bad_param
    $error("intr_flag_ctrl: DRAIN_CYCLES must be 1..7");
  end

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state, nxt;
  logic [2:0] cnt;
  logic [7:0] ret_pc;
  logic       in_service;
  logic       pending;
  logic       clr;

  intr_edge_sync u_edge (
    .CLK     (CLK),
    .RST     (RST),
    .intr    (INTR),
    .clr     (clr),
    .pending (pending)
  );

  // state register plus drain counter, return PC and service flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      ret_pc     <= '0;
      in_service <= 1'b0;
    end else begin
      state <= nxt;
      if (clr) begin
        cnt    <= DRAIN_LOAD;
        ret_pc <= PC_NEXT;
      end else if (state == DRAIN && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (state == JUMP)     in_service <= 1'b1;
      else if (state == RET) in_service <= 1'b0;
    end
  end

  // next-state and Moore output decode; RTI outranks a pending interrupt
  always_comb begin
    nxt          = state;
    clr          = 1'b0;
    STALL        = 1'b0;
    FLUSH        = 1'b0;
    F_SAVE       = 1'b0;
    F_RESTORE    = 1'b0;
    MEM_RD       = 1'b0;
    MEM_WR       = 1'b0;
    MEM_ADDR_SEL = SEL_NORM;
    MEM_WDATA    = '0;
    SP_DEC       = 1'b0;
    SP_INC       = 1'b0;
    PC_LOAD      = 1'b0;
    INT_ACK      = 1'b0;
    unique case (state)
      IDLE: begin
        if (RTI && in_service) begin
          nxt = POP;
        end else if (pending && !in_service) begin
          nxt = DRAIN;
          clr = 1'b1;
        end
      end
      DRAIN: begin
        STALL = 1'b1;
        if (cnt == 3'd0) nxt = SAVE;
      end
      SAVE: begin
        STALL  = 1'b1;
        F_SAVE = 1'b1;
        nxt    = PUSH;
      end
      PUSH: begin
        STALL        = 1'b1;
        MEM_WR       = 1'b1;
        MEM_ADDR_SEL = SEL_SP;
        MEM_WDATA    = ret_pc;
        SP_DEC       = 1'b1;
        nxt          = VEC;
      end
      VEC: begin
        STALL        = 1'b1;
        MEM_RD       = 1'b1;
        MEM_ADDR_SEL = SEL_VEC;
        nxt          = JUMP;
      end
      JUMP: begin
        PC_LOAD = 1'b1;
        FLUSH   = 1'b1;
        INT_ACK = 1'b1;
        nxt     = IDLE;
      end
      POP: begin
        STALL  = 1'b1;
        SP_INC = 1'b1;
        nxt    = POPRD;
      end
      POPRD: begin
        STALL        = 1'b1;
        MEM_RD       = 1'b1;
        MEM_ADDR_SEL = SEL_SP;
        nxt          = RET;
      end
      RET: begin
        PC_LOAD   = 1'b1;
        FLUSH     = 1'b1;
        F_RESTORE = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // redirect target comes straight from the memory read port
  assign PC_LOAD_VAL = PC_LOAD ? MEM_RDATA : 8'h00;
  assign IN_SERVICE  = in_service;

endmodule
